// File: rtl/dmem_bus_bridge_if.sv
// Bus-side signal bundle for dmem_bus_bridge: request/address-ok/data-ok handshake
// toward a variable-latency data SRAM or bus.
interface dmem_bus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                bus_req;
    logic                bus_wr;
    logic [DATA_W/8-1:0] bus_wstrb;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic                bus_addr_ok;
    logic                bus_data_ok;
    logic [DATA_W-1:0]   bus_rdata;
    logic                bus_err;

    modport master (
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, bus_err,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, bus_err,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Converts the MIPS M-stage data access into a req/addr_ok/data_ok bus transaction,
// holding stallM until it completes. Optional watchdog enabled by DMEM_TIMEOUT_EN.
module dmem_bus_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memenM,
    input  logic [DATA_W/8-1:0] memwriteM,
    input  logic [ADDR_W-1:0]   aluoutM,
    input  logic [DATA_W-1:0]   writedataM,
    output logic [DATA_W-1:0]   readdataM,
    output logic                stallM,
    dmem_bus_bridge_if.master   bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} bridgeStateT;

    bridgeStateT state, nextState;

    logic [ADDR_W-1:0]   addrQ;
    logic                wrQ;
    logic [DATA_W/8-1:0] strbQ;
    logic [DATA_W-1:0]   wdataQ;
    logic                reqValid;
    logic                accept;
    logic                capture;
    logic                timeoutNow;

    assign bus.bus_req   = reqValid;
    assign bus.bus_wr    = wrQ;
    assign bus.bus_wstrb = strbQ;
    assign bus.bus_addr  = addrQ;
    assign bus.bus_wdata = wdataQ;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] waitCnt;
    logic             errQ;
    logic             busy;

    assign busy       = (state == REQ) || (state == WAIT);
    assign timeoutNow = busy && (waitCnt == CNT_W'(TIMEOUT - 1));
    assign bus.bus_err = errQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt <= '0;
        end else if (accept) begin
            waitCnt <= '0;
        end else if (busy) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end
`else
    assign timeoutNow  = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A completing data_ok always wins over a watchdog expiry in the same cycle.
    always_comb begin
        nextState = state;
        stallM    = 1'b0;
        reqValid  = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                stallM = memenM && !rst;
                if (memenM) begin
                    accept    = 1'b1;
                    nextState = REQ;
                end
            end
            REQ: begin
                stallM   = 1'b1;
                reqValid = 1'b1;
                if (bus.bus_addr_ok && bus.bus_data_ok) begin
                    capture   = 1'b1;
                    nextState = DONE;
                end else if (timeoutNow) begin
                    nextState = DONE;
                end else if (bus.bus_addr_ok) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                stallM = 1'b1;
                if (bus.bus_data_ok) begin
                    capture   = 1'b1;
                    nextState = DONE;
                end else if (timeoutNow) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrQ     <= '0;
            wrQ       <= 1'b0;
            strbQ     <= '0;
            wdataQ    <= '0;
            readdataM <= '0;
        end else begin
            if (accept) begin
                addrQ  <= aluoutM;
                wrQ    <= |memwriteM;
                strbQ  <= memwriteM;
                wdataQ <= writedataM;
            end
            if (capture && !wrQ) begin
                readdataM <= bus.bus_rdata;
            end
`ifdef DMEM_TIMEOUT_EN
            if (timeoutNow && !capture && !wrQ) begin
                readdataM <= DATA_W'(32'hDEADBEEF);
            end
`endif
        end
    end

`ifdef DMEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errQ <= 1'b0;
        end else if (timeoutNow && !capture) begin
            errQ <= 1'b1;
        end
    end
`endif
endmodule
